data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//  Off-chip main data memory model downstream of the L1 data cache miss path.
//  - Serves whole 256-bit cache lines, one request at a time.
//  - Fixed multi-cycle latency, single-cycle ack pulse.
//  - Supports line fills (read) and dirty write-backs (write) issued by the dcache controller.
// PARAMETERS
//  LINE_W   256  line width in bits (= cache line)
//  DEPTH    512  number of lines (16 KiB)
//  ADDR_LSB 5    byte-offset bits dropped from addr_i (32-byte lines)
//  LATENCY  10   cycles from request sample to ack; must be >= 2
// PORTS
//  clk_i     in   1       clock, all state on posedge
//  rst_i     in   1       asynchronous, active-low reset
//  enable_i  in   1       request valid; held high by requester until ack_o
//  write_i   in   1       1 = write line, 0 = read line; sampled with enable_i
//  addr_i    in   32      byte address; line index = addr_i[ADDR_LSB+8:ADDR_LSB]
//  data_i    in   LINE_W  write line data; sampled with enable_i
//  ack_o     out  1       one-cycle completion pulse
//  data_o    out  LINE_W  read line data; valid with ack_o, held until next read completes
// BEHAVIOUR
//  Reset (rst_i=0, async)
//  - state=IDLE, cnt=0, ack_o=0, data_o=0.
//  - Array contents are NOT reset; the bench preloads them via hierarchical $readmemb.
//  FSM: IDLE -> BUSY -> ACK -> IDLE
//  - IDLE:
//    - Posedge with enable_i=1 (edge N): latch write_i, line index and data_i; cnt<=0; go BUSY.
//    - enable_i=0: stay IDLE.
//  - BUSY:
//    - Each posedge where cnt != LATENCY-1: cnt<=cnt+1.
//    - At edge N+LATENCY (cnt == LATENCY-1):
//      - write: mem[idx] <= latched data.
//      - read: data_o <= mem[idx].
//      - ack_o<=1; go ACK.
//    - Input changes during BUSY are ignored (latched copy used).
//  - ACK:
//    - ack_o high for exactly this cycle; next posedge: ack_o<=0, go IDLE.
//    - Requests are never sampled in ACK.
//  Handshake
//  - The requester updates enable_i/write_i on the ack edge.
//  - If enable_i is still high at the first IDLE edge, that is a NEW request.
//  - Write-back-then-fill sequence: enable_i held high, write_i drops on ack -> read issued back-to-back.
//  - Min request-to-request spacing is LATENCY+2 edges; no request is ever double-acked.
//  Boundary conditions
//  - Write data is committed only at completion.
//  - data_o is unchanged by writes, and is held stable after a read ack (the cache captures it a cycle later).
//  - Address bits above the index are ignored (aliasing wraps modulo DEPTH); bits below ADDR_LSB are ignored.
//  - Reset mid-BUSY aborts the access: no array write, no ack, FSM returns to IDLE.
//  - enable_i deasserted mid-BUSY does not cancel; the access completes and acks.
//  - Width: cnt is $clog2(LATENCY) bits and never exceeds LATENCY-1.
// TESTING
//  1 Preload mem[3]=256'hA5..A5; read addr 32'h60 at edge N -> ack_o high only in the cycle after edge N+10; data_o=A5..A5 and held after ack.
//  2 Write 256'h1234 to addr 32'h400, then read addr 32'h400 -> data_o=256'h1234; data_o unchanged during the write.
//  3 Write-back addr 32'h80 with enable_i held, write_i dropped on ack, read addr 32'hC0 -> two acks 12 edges apart; mem[4] updated; data_o=mem[6].
//  4 Assert rst_i=0 at BUSY cnt=5 of a write to line 7 -> ack_o=0, data_o=0, mem[7] unchanged; a new read after reset completes in LATENCY.
//  5 Read addr 32'h0000_4060 (alias of line 3) -> returns mem[3]; addr 32'h7F returns mem[3] (offset ignored).
//  6 Drop enable_i at BUSY cnt=2 and toggle addr_i/write_i -> access completes with the latched values, a single ack, then IDLE with no new request.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: fixed-latency, line-wide backing store serving dcache fills and write-backs
module data_memory #(
    parameter int LINE_W   = 256,
    parameter int DEPTH    = 512,
    parameter int ADDR_LSB = 5,
    parameter int LATENCY  = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_write;
    logic [IDX_W-1:0]  r_idx;
    logic [LINE_W-1:0] r_data;
    logic [LINE_W-1:0] r_mem [DEPTH];
    logic              w_done;
    logic              w_unused;

    assign w_done   = (r_state == BUSY) && (r_cnt == CNT_W'(LATENCY - 1));
    assign w_unused = &{1'b0, addr_i[31:ADDR_LSB+IDX_W], addr_i[ADDR_LSB-1:0]};

    // Request sequencing: latch on accept, count out the latency, pulse ack for one cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
            ack_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            case (r_state)
                IDLE: if (enable_i) begin
                    r_state <= BUSY;
                    r_cnt   <= '0;
                    r_write <= write_i;
                    r_idx   <= addr_i[ADDR_LSB +: IDX_W];
                    r_data  <= data_i;
                end
                BUSY: if (w_done) begin
                    r_state <= ACK;
                    ack_o   <= 1'b1;
                    if (!r_write) data_o <= r_mem[r_idx];
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                ACK: begin
                    r_state <= IDLE;
                    ack_o   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Array commit happens only on completion, so an access aborted by reset never writes
    always_ff @(posedge clk_i) begin
        if (w_done && r_write) r_mem[r_idx] <= r_data;
    end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized scoreboard bench for data_memory against a line-array model
module tb_data_memory;
    localparam int LAT = 10;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         enable_i = 1'b0;
    logic         write_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic [255:0] data_i = '0;
    logic         ack_o;
    logic [255:0] data_o;

    data_memory dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
        .addr_i(addr_i), .data_i(data_i), .ack_o(ack_o), .data_o(data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit           wr;
        int           idx;
        logic [255:0] data;
        int           ack_at;
    } exp_t;

    exp_t         q[$];
    logic [255:0] mdl [512];
    logic [255:0] exp_dout = '0;
    int           ec = 0;
    int           n_chk = 0;
    int           n_fail = 0;
    bit           after_ack = 0;

    always @(posedge clk_i) ec <= ec + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: checks every ack against the scoreboard and data_o against the model every cycle
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            q.delete();
            exp_dout = '0;
            chk("reset_ack", {255'b0, ack_o}, 256'd0);
            chk("reset_dout", data_o, 256'd0);
        end else begin
            if (ack_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_ack", 256'd1, 256'd0);
                end else begin
                    e = q.pop_front();
                    chk("ack_edge", 256'(ec), 256'(e.ack_at));
                    if (e.wr) mdl[e.idx] = e.data;
                    else exp_dout = mdl[e.idx];
                end
            end
            chk("dout", data_o, exp_dout);
        end
    end

    task automatic req(input bit w, input logic [31:0] a, input logic [255:0] d,
                       input bit keep, input int mess);
        bit got;
        enable_i = 1'b1;
        write_i  = w;
        addr_i   = a;
        data_i   = d;
        if (after_ack) @(posedge clk_i);
        @(posedge clk_i);
        #1;
        q.push_back('{wr: w, idx: int'((a / 32) % 512), data: d, ack_at: ec + LAT});
        if (mess > 0) begin
            repeat (mess) @(posedge clk_i);
            #1;
            enable_i = 1'b0;
            write_i  = ~w;
            addr_i   = $urandom;
            data_i   = rnd256();
        end
        got = 0;
        for (int k = 0; k < 3 * LAT; k++) begin
            @(negedge clk_i);
            if (ack_o) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("ack_timeout", 256'd0, 256'd1);
        if (!keep) enable_i = 1'b0;
        after_ack = 1;
    endtask

    task automatic idle(input int n);
        enable_i = 1'b0;
        repeat (n) @(negedge clk_i);
        after_ack = 0;
    endtask

    initial begin
        logic [255:0] d;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 512; i++) req(1'b1, 32'(i * 32), rnd256(), 1'b1, 0);
        idle(2);

        req(1'b1, 32'h60, {32{8'hA5}}, 1'b0, 0);
        idle(1);
        req(1'b0, 32'h60, '0, 1'b0, 0);
        idle(4);

        req(1'b1, 32'h400, 256'h1234, 1'b0, 0);
        idle(2);
        req(1'b0, 32'h400, '0, 1'b0, 0);
        idle(2);

        req(1'b1, 32'h80, rnd256(), 1'b1, 0);
        req(1'b0, 32'hC0, '0, 1'b0, 0);
        idle(2);
        req(1'b0, 32'h80, '0, 1'b0, 0);
        idle(2);

        d = rnd256();
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 32'(7 * 32);
        data_i   = d;
        @(posedge clk_i);
        repeat (5) @(posedge clk_i);
        #1;
        rst_i    = 1'b0;
        enable_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        idle(1);
        req(1'b0, 32'(7 * 32), '0, 1'b0, 0);
        idle(2);

        req(1'b0, 32'h0000_4060, '0, 1'b0, 0);
        idle(1);
        req(1'b0, 32'h7F, '0, 1'b0, 0);
        idle(2);

        req(1'b1, 32'h1A0, rnd256(), 1'b0, 2);
        idle(15);
        req(1'b0, 32'h1A0, '0, 1'b0, 0);
        idle(2);

        for (int i = 0; i < 80; i++) begin
            req(1'($urandom), $urandom, rnd256(), 1'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)));
        end
        idle(3 * LAT);
        chk("queue_drained", 256'(q.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
